// File: rtl/feature_frame_serializer.sv
// Feature frame serializer: captures one feature frame and streams it as
// sync, mode, label, sequence, channel bytes and an XOR checksum.
module feature_frame_serializer #(
    parameter int         INPUT_CHANNELS = 64,
    parameter int         CHANNEL_WIDTH  = 8,
    parameter int         MODE_WIDTH     = 2,
    parameter int         LABEL_WIDTH    = 5,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                                    Clk_CI,
    input  logic                                    Reset_RBI,
    input  logic                                    ValidIn_SI,
    output logic                                    ReadyOut_SO,
    input  logic [MODE_WIDTH-1:0]                   ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0]                  LabelIn_DI,
    input  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] ChannelsIn_DI,
    output logic [7:0]                              DataOut_DO,
    output logic                                    ValidOut_SO,
    input  logic                                    ReadyIn_SI,
    output logic [7:0]                              SeqCntr_DO
);

    localparam int N     = INPUT_CHANNELS + 5;
    localparam int IDX_W = $clog2(N);

    localparam logic [IDX_W-1:0] IDX_MODE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LABEL = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_SEQ   = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [7:0]               csum;
    logic [7:0]               seq;
    logic [7:0]               seq_q;
    logic [MODE_WIDTH-1:0]    mode_q;
    logic [LABEL_WIDTH-1:0]   label_q;
    logic [CHANNEL_WIDTH-1:0] chan_q [INPUT_CHANNELS];
    logic [7:0]               cur_byte;
    logic                     capture;
    logic                     xfer;

    assign capture    = (state == IDLE) && ValidIn_SI;
    assign xfer       = (state == SEND) && ReadyIn_SI;
    assign DataOut_DO = cur_byte;
    assign SeqCntr_DO = seq;

    // State register
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        ReadyOut_SO = 1'b0;
        ValidOut_SO = 1'b0;
        unique case (state)
            IDLE: begin
                ReadyOut_SO = 1'b1;
                if (ValidIn_SI) state_nxt = SEND;
            end
            SEND: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI && idx == IDX_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte selection from the registered frame; zero while idle
    always_comb begin
        cur_byte = '0;
        if (state == SEND) begin
            if (idx == '0) begin
                cur_byte = SYNC_BYTE;
            end else if (idx == IDX_MODE) begin
                cur_byte[MODE_WIDTH-1:0] = mode_q;
            end else if (idx == IDX_LABEL) begin
                cur_byte[LABEL_WIDTH-1:0] = label_q;
            end else if (idx == IDX_SEQ) begin
                cur_byte = seq_q;
            end else if (idx == IDX_LAST) begin
                cur_byte = csum;
            end else begin
                for (int j = 0; j < INPUT_CHANNELS; j++) begin
                    if (idx == IDX_W'(j + 4)) begin
                        cur_byte[CHANNEL_WIDTH-1:0] = chan_q[j];
                    end
                end
            end
        end
    end

    // Frame capture, byte index, running checksum and sequence counter
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            idx     <= '0;
            csum    <= '0;
            seq     <= '0;
            seq_q   <= '0;
            mode_q  <= '0;
            label_q <= '0;
            for (int j = 0; j < INPUT_CHANNELS; j++) chan_q[j] <= '0;
        end else if (capture) begin
            idx     <= '0;
            csum    <= '0;
            seq_q   <= seq;
            mode_q  <= ModeIn_SI;
            label_q <= LabelIn_DI;
            for (int j = 0; j < INPUT_CHANNELS; j++) begin
                chan_q[j] <= ChannelsIn_DI[j*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            end
        end else if (xfer) begin
            if (idx == IDX_LAST) begin
                idx <= '0;
                seq <= seq + 8'd1;
            end else begin
                idx <= idx + IDX_W'(1);
                if (idx != '0) csum <= csum ^ cur_byte;
            end
        end
    end

endmodule
